// File: rtl/led_pdm_scanner.sv
// HUB75 scan engine for a 64x64 panel: requests pixels from a painter, converts each
// colour to per-subframe PDM bits, shifts half-rows out, then blanks, latches and steps the row.
module led_pdm_scanner #(
    parameter int DELAY      = 1,
    parameter int FRAME_BITS = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic [FRAME_BITS-1:0] frame,
    output logic [7:0]            subframe,
    output logic [5:0]            x,
    output logic [5:0]            y,
    input  logic [23:0]           rgb24,
    output logic [2:0]            led_rgb0,
    output logic [2:0]            led_rgb1,
    output logic [4:0]            led_addr,
    output logic                  led_blank,
    output logic                  led_latch,
    output logic                  led_sclk
);

    typedef enum logic [1:0] {
        SHIFT,
        BLANK,
        LATCH
    } state_t;

    localparam logic [7:0]            DLY_LAST  = 8'(DELAY - 1);
    localparam logic [FRAME_BITS-1:0] FRAME_ONE = {{(FRAME_BITS-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [5:0]            col_q, col_d;
    logic [1:0]            phase_q, phase_d;
    logic [4:0]            row_q, row_d;
    logic [7:0]            subframe_q, subframe_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [7:0]            dly_q, dly_d;
    logic [2:0]            hold_q, hold_d;
    logic [2:0]            rgb0_q, rgb0_d;
    logic [2:0]            rgb1_q, rgb1_d;
    logic [4:0]            addr_q, addr_d;
    logic                  sclk_q, sclk_d;
    logic                  first_row_q, first_row_d;

    logic [7:0]            th;
    logic [2:0]            pdm_bits;

    // Bit-reversed subframe spreads each channel's on-time evenly across the 256 subframes.
    always_comb begin
        th = '0;
        for (int i = 0; i < 8; i++) begin
            th[i] = subframe_q[7-i];
        end
    end

    assign pdm_bits = {rgb24[23:16] > th, rgb24[15:8] > th, rgb24[7:0] > th};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= SHIFT;
            col_q       <= '0;
            phase_q     <= '0;
            row_q       <= '0;
            subframe_q  <= '0;
            frame_q     <= '0;
            dly_q       <= '0;
            hold_q      <= '0;
            rgb0_q      <= '0;
            rgb1_q      <= '0;
            addr_q      <= '0;
            sclk_q      <= 1'b0;
            first_row_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            phase_q     <= phase_d;
            row_q       <= row_d;
            subframe_q  <= subframe_d;
            frame_q     <= frame_d;
            dly_q       <= dly_d;
            hold_q      <= hold_d;
            rgb0_q      <= rgb0_d;
            rgb1_q      <= rgb1_d;
            addr_q      <= addr_d;
            sclk_q      <= sclk_d;
            first_row_q <= first_row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SHIFT:   if (phase_q == 2'd3 && col_q == 6'd63) state_d = BLANK;
            BLANK:   if (dly_q == DLY_LAST) state_d = LATCH;
            LATCH:   state_d = SHIFT;
            default: state_d = SHIFT;
        endcase
    end

    always_comb begin
        col_d       = col_q;
        phase_d     = phase_q;
        row_d       = row_q;
        subframe_d  = subframe_q;
        frame_d     = frame_q;
        dly_d       = '0;
        hold_d      = hold_q;
        rgb0_d      = rgb0_q;
        rgb1_d      = rgb1_q;
        addr_d      = addr_q;
        sclk_d      = sclk_q;
        first_row_d = first_row_q;
        case (state_q)
            SHIFT: begin
                phase_d = phase_q + 2'd1;
                // Painter answers one clock late: top pixel arrives in phase 1, bottom in phase 2.
                if (phase_q == 2'd1) begin
                    hold_d = pdm_bits;
                end
                if (phase_q == 2'd2) begin
                    rgb0_d = hold_q;
                    rgb1_d = pdm_bits;
                    sclk_d = 1'b1;
                end
                if (phase_q == 2'd3) begin
                    sclk_d = 1'b0;
                    col_d  = col_q + 6'd1;
                end
            end
            BLANK: begin
                dly_d = dly_q + 8'd1;
            end
            LATCH: begin
                addr_d      = row_q;
                row_d       = row_q + 5'd1;
                first_row_d = 1'b0;
                if (row_q == 5'd31) begin
                    subframe_d = subframe_q + 8'd1;
                    if (subframe_q == 8'd255) begin
                        frame_d = frame_q + FRAME_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        x         = col_q;
        y         = {(phase_q != 2'd0), row_q};
        frame     = frame_q;
        subframe  = subframe_q;
        led_rgb0  = rgb0_q;
        led_rgb1  = rgb1_q;
        led_addr  = addr_q;
        led_sclk  = sclk_q;
        led_latch = (state_q == LATCH);
        led_blank = first_row_q || (state_q != SHIFT);
    end

endmodule
